// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// The default timeout is only consumed when MULDIV_TIMEOUT_EN is defined.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MRUN  = 3'd1,
    DRUN  = 3'd2,
    WB    = 3'd3,
    FAULT = 3'd4
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd64;

endpackage

// File: rtl/muldiv_timeout.sv
// Run-state watchdog counter for muldiv_sched; compiled only when
// MULDIV_TIMEOUT_EN is defined.
`ifdef MULDIV_TIMEOUT_EN
module muldiv_timeout #(
  parameter int unsigned CYCLES = 32'd64
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = (CYCLES > 32'd1) ? $clog2(CYCLES) : 32'd1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 32'd1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear wins over count; the counter only advances while a run state is active.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule
`endif

// File: rtl/muldiv_sched.sv
// Sequencer for the shared multiply/divide engines: captures operands, launches
// one engine, waits for completion and drives HI/LO writeback. Optional run
// watchdog is enabled with MULDIV_TIMEOUT_EN.
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int unsigned W = 32'd32
`ifdef MULDIV_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         op_start,
  input  logic         op_div,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [W-1:0] eng_a,
  output logic [W-1:0] eng_b,
  output logic         mult_start,
  input  logic         mult_done,
  input  logic [W-1:0] mult_hi,
  input  logic [W-1:0] mult_lo,
  output logic         div_start,
  input  logic         div_done,
  input  logic [W-1:0] div_hi,
  input  logic [W-1:0] div_lo,
  output logic         hi_we,
  output logic         lo_we,
  output logic [W-1:0] hi_data,
  output logic [W-1:0] lo_data,
  output logic         busy,
  output logic         done,
  output logic         divz,
  output logic         err,
  output logic         op_reject
);

  state_e         state_q, state_d;
  logic [W-1:0]   eng_a_q, eng_a_d;
  logic [W-1:0]   eng_b_q, eng_b_d;
  logic [W-1:0]   hi_data_q, hi_data_d;
  logic [W-1:0]   lo_data_q, lo_data_d;
  logic           mult_start_q, mult_start_d;
  logic           div_start_q, div_start_d;
  logic           wb_q, wb_d;
  logic           busy_q, busy_d;
  logic           divz_q, divz_d;
  logic           err_q, err_d;
  logic           op_reject_q, op_reject_d;
  logic           timeout_s;

`ifdef MULDIV_TIMEOUT_EN
  muldiv_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (state_q == IDLE),
    .en_i      ((state_q == MRUN) || (state_q == DRUN)),
    .expired_o (timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-output logic; pulses default low, data registers hold.
  always_comb begin
    state_d      = state_q;
    eng_a_d      = eng_a_q;
    eng_b_d      = eng_b_q;
    hi_data_d    = hi_data_q;
    lo_data_d    = lo_data_q;
    mult_start_d = 1'b0;
    div_start_d  = 1'b0;
    wb_d         = 1'b0;
    divz_d       = 1'b0;
    err_d        = 1'b0;
    op_reject_d  = op_start && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (op_start) begin
          if (op_div == OP_DIV) begin
            if (b_in == '0) begin
              state_d = FAULT;
              divz_d  = 1'b1;
            end else begin
              state_d     = DRUN;
              div_start_d = 1'b1;
              eng_a_d     = a_in;
              eng_b_d     = b_in;
            end
          end else begin
            state_d      = MRUN;
            mult_start_d = 1'b1;
            eng_a_d      = a_in;
            eng_b_d      = b_in;
          end
        end else begin
          state_d = IDLE;
        end
      end

      // A done seen while the launch pulse is still out belongs to no request of ours.
      MRUN: begin
        if (mult_done && !mult_start_q) begin
          state_d   = WB;
          hi_data_d = mult_hi;
          lo_data_d = mult_lo;
          wb_d      = 1'b1;
        end else if (timeout_s) begin
          state_d = FAULT;
          err_d   = 1'b1;
        end else begin
          state_d = MRUN;
        end
      end

      DRUN: begin
        if (div_done && !div_start_q) begin
          state_d   = WB;
          hi_data_d = div_hi;
          lo_data_d = div_lo;
          wb_d      = 1'b1;
        end else if (timeout_s) begin
          state_d = FAULT;
          err_d   = 1'b1;
        end else begin
          state_d = DRUN;
        end
      end

      WB:      state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      eng_a_q      <= '0;
      eng_b_q      <= '0;
      hi_data_q    <= '0;
      lo_data_q    <= '0;
      mult_start_q <= 1'b0;
      div_start_q  <= 1'b0;
      wb_q         <= 1'b0;
      busy_q       <= 1'b0;
      divz_q       <= 1'b0;
      err_q        <= 1'b0;
      op_reject_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      eng_a_q      <= eng_a_d;
      eng_b_q      <= eng_b_d;
      hi_data_q    <= hi_data_d;
      lo_data_q    <= lo_data_d;
      mult_start_q <= mult_start_d;
      div_start_q  <= div_start_d;
      wb_q         <= wb_d;
      busy_q       <= busy_d;
      divz_q       <= divz_d;
      err_q        <= err_d;
      op_reject_q  <= op_reject_d;
    end
  end

  assign eng_a      = eng_a_q;
  assign eng_b      = eng_b_q;
  assign mult_start = mult_start_q;
  assign div_start  = div_start_q;
  assign hi_we      = wb_q;
  assign lo_we      = wb_q;
  assign done       = wb_q;
  assign hi_data    = hi_data_q;
  assign lo_data    = lo_data_q;
  assign busy       = busy_q;
  assign divz       = divz_q;
  assign err        = err_q;
  assign op_reject  = op_reject_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: stub engines plus a cycle-count model
// of each request derived from the accept edge and the engine latency.
module tb_muldiv_sched;

  logic        clock;
  logic        reset;
  logic        op_start, op_div;
  logic [31:0] a_in, b_in;
  logic [31:0] eng_a, eng_b;
  logic        mult_start, mult_done, div_start, div_done;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic        hi_we, lo_we, busy, done, divz, err, op_reject;
  logic [31:0] hi_data, lo_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_eng_a, m_eng_b, m_hi, m_lo;

`ifdef MULDIV_TIMEOUT_EN
  localparam int MULT_LAT = 15;
`else
  localparam int MULT_LAT = 33;
`endif

  muldiv_sched #(
    .W (32)
`ifdef MULDIV_TIMEOUT_EN
    , .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .op_start   (op_start),
    .op_div     (op_div),
    .a_in       (a_in),
    .b_in       (b_in),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .mult_start (mult_start),
    .mult_done  (mult_done),
    .mult_hi    (mult_hi),
    .mult_lo    (mult_lo),
    .div_start  (div_start),
    .div_done   (div_done),
    .div_hi     (div_hi),
    .div_lo     (div_lo),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .hi_data    (hi_data),
    .lo_data    (lo_data),
    .busy       (busy),
    .done       (done),
    .divz       (divz),
    .err        (err),
    .op_reject  (op_reject)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic e_busy, input logic e_ms,
                               input logic e_ds, input logic e_wb, input logic e_divz,
                               input logic e_err, input logic e_rej,
                               input logic [31:0] e_ea, input logic [31:0] e_eb,
                               input logic [31:0] e_hi, input logic [31:0] e_lo);
    chk({tag, ".busy"},       busy,       e_busy);
    chk({tag, ".mult_start"}, mult_start, e_ms);
    chk({tag, ".div_start"},  div_start,  e_ds);
    chk({tag, ".hi_we"},      hi_we,      e_wb);
    chk({tag, ".lo_we"},      lo_we,      e_wb);
    chk({tag, ".done"},       done,       e_wb);
    chk({tag, ".divz"},       divz,       e_divz);
    chk({tag, ".err"},        err,        e_err);
    chk({tag, ".op_reject"},  op_reject,  e_rej);
    chk({tag, ".eng_a"},      eng_a,      e_ea);
    chk({tag, ".eng_b"},      eng_b,      e_eb);
    chk({tag, ".hi_data"},    hi_data,    e_hi);
    chk({tag, ".lo_data"},    lo_data,    e_lo);
  endtask

  // One request issued in an idle cycle (cycle 0). The selected engine reports
  // done in cycle lat+1; writeback is expected in cycle lat+2 and the block is
  // idle again in cycle lat+3 (cycle 2 for a divide by zero). Returns at the
  // negedge of that first idle cycle so the next request can go back-to-back.
  task automatic do_op(input string name, input bit div, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input int rej1,
                       input int rej2, input bit level);
    bit          z;
    int          last;
    longint      prod;
    logic [31:0] eh, el, ea, eb;
    bit          sel_done;
    z    = div && (b == 32'd0);
    last = z ? 2 : lat + 3;
    if (div) begin
      eh = z ? m_hi : (a % b);
      el = z ? m_lo : (a / b);
    end else begin
      prod = longint'($signed(a)) * longint'($signed(b));
      eh   = prod[63:32];
      el   = prod[31:0];
    end
    ea = z ? m_eng_a : a;
    eb = z ? m_eng_b : b;

    op_start = 1'b1; op_div = div; a_in = a; b_in = b;
    mult_done = 1'b0; div_done = 1'b0;
    for (int c = 1; c <= last; c++) begin
      @(negedge clock);
      check_outputs($sformatf("%s.c%0d", name, c),
                    c < last, !div && c == 1, div && !z && c == 1,
                    !z && c == lat + 2, z && c == 1, 1'b0,
                    (rej1 >= 1 && c - 1 == rej1) || (rej2 >= 1 && c - 1 == rej2),
                    ea, eb,
                    (!z && c >= lat + 2) ? eh : m_hi,
                    (!z && c >= lat + 2) ? el : m_lo);
      op_start = (c < last) && (c == rej1 || c == rej2);
      op_div   = 1'($urandom_range(1, 0));
      a_in     = $urandom;
      b_in     = $urandom;
      sel_done = !z && ((c == 1 && $urandom_range(1, 0) == 1) || c == lat + 1 ||
                        (level && c > lat + 1 && c < last));
      mult_hi = $urandom; mult_lo = $urandom; div_hi = $urandom; div_lo = $urandom;
      if (div) begin
        div_done  = sel_done;
        mult_done = 1'($urandom_range(1, 0));
        if (c == lat + 1) begin div_hi = eh; div_lo = el; end
      end else begin
        mult_done = sel_done;
        div_done  = 1'($urandom_range(1, 0));
        if (c == lat + 1) begin mult_hi = eh; mult_lo = el; end
      end
    end
    op_start = 1'b0;
    m_eng_a = ea; m_eng_b = eb;
    if (!z) begin m_hi = eh; m_lo = el; end
  endtask

  bit          r_div, r_lvl;
  logic [31:0] r_a, r_b;
  int          r_lat, r_last, r_rej;

  initial begin
    reset = 1'b0;
    op_start = 1'b0; op_div = 1'b0; a_in = 32'd0; b_in = 32'd0;
    mult_done = 1'b0; div_done = 1'b0;
    mult_hi = 32'd0; mult_lo = 32'd0; div_hi = 32'd0; div_lo = 32'd0;
    m_eng_a = 32'd0; m_eng_b = 32'd0; m_hi = 32'd0; m_lo = 32'd0;

    repeat (2) @(negedge clock);
    check_outputs("reset", 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check_outputs("idle", 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0);

    do_op("mult", 1'b0, 32'd7, 32'hFFFF_FFFD, MULT_LAT, -1, -1, 1'b0);
    chk("mult.hi", m_hi, 32'hFFFF_FFFF);
    chk("mult.lo", m_lo, 32'hFFFF_FFEB);
    do_op("div", 1'b1, 32'd100, 32'd7, 5, -1, -1, 1'b0);
    chk("div.hi", hi_data, 32'd2);
    chk("div.lo", lo_data, 32'd14);
    do_op("divz", 1'b1, 32'd55, 32'd0, 1, -1, -1, 1'b0);
    do_op("reject", 1'b0, 32'd9, 32'd11, 10, 5, 11, 1'b1);
    do_op("minlat", 1'b1, 32'hDEAD_BEEF, 32'd3, 1, 2, -1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      r_div  = 1'($urandom_range(1, 0));
      r_a    = $urandom;
      r_b    = ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom;
      r_lat  = $urandom_range(12, 1);
      r_lvl  = 1'($urandom_range(1, 0));
      r_last = (r_div && r_b == 32'd0) ? 2 : r_lat + 3;
      r_rej  = ($urandom_range(1, 0) == 1) ? $urandom_range(r_last - 1, 1) : -1;
      do_op($sformatf("rnd%0d", i), r_div, r_a, r_b, r_lat, r_rej, -1, r_lvl);
      if ($urandom_range(1, 0) == 1) begin
        @(negedge clock);
        check_outputs($sformatf("gap%0d", i), 0, 0, 0, 0, 0, 0, 0, m_eng_a, m_eng_b, m_hi, m_lo);
      end
    end

    // Reset five cycles into a divide; the late engine result must be dropped.
    op_start = 1'b1; op_div = 1'b1; a_in = 32'd100; b_in = 32'd7;
    @(negedge clock);
    op_start = 1'b0;
    repeat (5) @(negedge clock);
    chk("rst.busy_before", busy, 1'b1);
    #2 reset = 1'b0;
    #1 check_outputs("rst.async", 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0);
    m_eng_a = 32'd0; m_eng_b = 32'd0; m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clock);
    reset = 1'b1;
    div_done = 1'b1; div_hi = 32'd2; div_lo = 32'd14;
    @(negedge clock);
    div_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check_outputs($sformatf("rst.after%0d", c), 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0);
    end
    do_op("post_rst", 1'b0, 32'd6, 32'd5, 4, -1, -1, 1'b0);

    // Engine never completes.
    op_start = 1'b1; op_div = 1'b0; a_in = 32'd3; b_in = 32'd4;
    mult_done = 1'b0; div_done = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
    for (int c = 1; c <= 18; c++) begin
      @(negedge clock);
      op_start = 1'b0;
      check_outputs($sformatf("tmo.c%0d", c), c <= 17, c == 1, 0, 0, 0, c == 17, 0,
                    32'd3, 32'd4, m_hi, m_lo);
    end
`else
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clock);
      op_start = 1'b0;
      chk($sformatf("hang.busy.c%0d", c), busy, 1'b1);
      chk($sformatf("hang.err.c%0d", c), err, 1'b0);
      chk($sformatf("hang.we.c%0d", c), hi_we, 1'b0);
    end
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    m_eng_a = 32'd0; m_eng_b = 32'd0; m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clock);
`endif
    do_op("final", 1'b1, 32'd1000, 32'd33, 3, -1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Sequencer for the shared multiply/divide resource in the multicycle CPU. Accepts one-cycle operation requests from the main control unit and captures the A/B operands. It launches the multiplier or divider engine and waits for that engine's completion, then drives the HI/LO write enables and result data. It also flags divide-by-zero and engine timeouts, so the control unit only needs to watch `busy`, `done` and `err`.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum cycles spent in a run state before aborting (only with `MULDIV_TIMEOUT_EN`).
- `W`, 32: operand and result width.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `op_start` in 1: one-cycle request pulse from the control unit.
- `op_div` in 1: 0 = mult, 1 = div; sampled with `op_start`.
- `a_in`, `b_in` in W: operands (A/B register outputs); sampled with `op_start`.
- `eng_a`, `eng_b` out W: latched operands fed to both engines.
- `mult_start` out 1: one-cycle multiplier launch pulse.
- `mult_done` in 1: multiplier completion, level or pulse.
- `mult_hi`, `mult_lo` in W: multiplier results.
- `div_start` out 1: one-cycle divider launch pulse.
- `div_done` in 1: divider completion.
- `div_hi`, `div_lo` in W: divider results (remainder, quotient).
- `hi_we`, `lo_we` out 1: HI/LO register write enables.
- `hi_data`, `lo_data` out W: HI/LO write data.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse coinciding with `hi_we`/`lo_we`.
- `divz` out 1: one-cycle pulse on a div request with `b_in == 0`.
- `err` out 1: one-cycle pulse on timeout.
- `op_reject` out 1: one-cycle pulse when `op_start` arrives while busy.

## Operation
- **States:** IDLE, MRUN, DRUN, WB, FAULT. All outputs are registered.
- **IDLE, `op_start` with `op_div=0`:** latch `eng_a`/`eng_b`, go to MRUN, `mult_start`=1 for the next cycle only.
- **IDLE, `op_start` with `op_div=1` and `b_in != 0`:** latch operands, go to DRUN, `div_start`=1 for the next cycle.
- **IDLE, `op_start` with `op_div=1` and `b_in == 0`:** go to FAULT. `divz`=1 for that cycle. No engine start, no HI/LO write.
- **MRUN/DRUN:** wait for the selected engine's done.
  - Done is ignored in the cycle `*_start` is high.
  - Done from the unselected engine is ignored.
  - On done sampled high: register the selected hi/lo into `hi_data`/`lo_data`, go to WB.
- **WB:** `hi_we`=`lo_we`=`done`=1 for one cycle, then IDLE.
- **FAULT:** one cycle, then IDLE. `hi_data`/`lo_data` hold their previous values.
- **`op_start` in any state other than IDLE:** ignored; `op_reject` pulses the next cycle; operands are not disturbed.
- **`op_start` in the same cycle as engine done:** rejected, because the block is still busy.
- **Reset (asserted at any time, including mid-run):** all state and outputs go to 0 immediately, state goes to IDLE. An in-flight engine result arriving after reset is ignored.

## Timing
- **Reset values:** `eng_a`, `eng_b`, `hi_data`, `lo_data` = 0. Every 1-bit output = 0.
- **Request accepted at edge 0:** `busy` and `*_start` are high in cycle 1; `*_start` drops in cycle 2.
- **Engine done sampled at edge k (k ≥ 2):** `hi_we`/`lo_we`/`done` are high in cycle k+1; `busy` drops in cycle k+2.
- **Minimum accept-to-done latency:** 3 cycles.
- **Divide-by-zero:** `divz` and `busy` are high in cycle 1; IDLE in cycle 2.
- **Back-to-back:** a new `op_start` is accepted in the first cycle `busy`=0.

## Configuration
- **`MULDIV_TIMEOUT_EN` defined:**
  - A `$clog2(TIMEOUT_CYCLES)` counter clears on entry to MRUN/DRUN and increments each run cycle.
  - If the count reaches `TIMEOUT_CYCLES-1` without done: go to FAULT, `err`=1 for one cycle, no HI/LO write.
  - If done and timeout occur in the same cycle, done wins.
- **Not defined:** no counter exists, `err` is tied to 0, and the run states wait indefinitely.

## Structure
- **Shared package `muldiv_pkg`:** state enum (IDLE, MRUN, DRUN, WB, FAULT), op-select constants `OP_MULT`=0 / `OP_DIV`=1, default `TIMEOUT_CYCLES`.
- **Sub-module `muldiv_timeout`:** counter with clear/enable/expired, instantiated only under `MULDIV_TIMEOUT_EN`.
- **Main body:** the FSM and output registers stay in `muldiv_sched`.

## Test plan
- **Mult:** `a_in`=7, `b_in`=-3 (0xFFFFFFFD), stub multiplier raises done 33 cycles after `mult_start` with hi=0xFFFFFFFF, lo=0xFFFFFFEB → exactly one `mult_start` pulse, no `div_start`, `hi_we`/`lo_we`/`done` high one cycle after done with those exact values.
- **Div:** `a_in`=100, `b_in`=7, stub divider done with hi=2, lo=14 → `hi_data`=2, `lo_data`=14, `busy` low two cycles after done.
- **Divide-by-zero:** div request with `b_in`=0 → `divz` pulse in cycle 1, no `div_start`, no writes, `hi_data`/`lo_data` unchanged, next request accepted in cycle 2.
- **Busy reject:** `op_start` during MRUN and again in the done cycle → `op_reject` pulses twice, `eng_a`/`eng_b` unchanged, only one writeback.
- **Mid-run reset:** `reset` pulled low 5 cycles into DRUN, then released, then stub `div_done` fires → outputs all 0 immediately, no `hi_we`, block accepts a fresh mult request.
- **Timeout (`MULDIV_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16):** engine never completes → `err` pulse after 16 run cycles, IDLE the following cycle, no writes; with the macro off, `busy` stays high for 1000 cycles.
